// File: rtl/kb_ps2_pkg.sv
// kb_ps2_pkg: key indices, PS/2 special bytes, scan-code-to-matrix map and composite key table
// Shared by ps2_rx (receiver state type) and ps2_kb_matrix (decoder).
// Composite helpers are only referenced when KB_COMPOSITE_KEYS_EN is defined.
package kb_ps2_pkg;
    localparam logic [5:0] KB_CS  = 6'd0,  KB_Z = 6'd1,  KB_X = 6'd2,  KB_C = 6'd3,  KB_V = 6'd4;
    localparam logic [5:0] KB_A   = 6'd5,  KB_S = 6'd6,  KB_D = 6'd7,  KB_F = 6'd8,  KB_G = 6'd9;
    localparam logic [5:0] KB_Q   = 6'd10, KB_W = 6'd11, KB_E = 6'd12, KB_R = 6'd13, KB_T = 6'd14;
    localparam logic [5:0] KB_1   = 6'd15, KB_2 = 6'd16, KB_3 = 6'd17, KB_4 = 6'd18, KB_5 = 6'd19;
    localparam logic [5:0] KB_0   = 6'd20, KB_9 = 6'd21, KB_8 = 6'd22, KB_7 = 6'd23, KB_6 = 6'd24;
    localparam logic [5:0] KB_P   = 6'd25, KB_O = 6'd26, KB_I = 6'd27, KB_U = 6'd28, KB_Y = 6'd29;
    localparam logic [5:0] KB_ENT = 6'd30, KB_L = 6'd31, KB_K = 6'd32, KB_J = 6'd33, KB_H = 6'd34;
    localparam logic [5:0] KB_SP  = 6'd35, KB_SS = 6'd36, KB_M = 6'd37, KB_N = 6'd38, KB_B = 6'd39;
    localparam logic [7:0] PS2_EXT = 8'hE0, PS2_BRK = 8'hF0, PS2_PAUSE = 8'hE1, PS2_BAT = 8'hAA;
    localparam int PAUSE_SKIP = 7;
    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_e;
    // {ext, code} -> {hit, matrix index}
    function automatic logic [6:0] kb_map(input logic ext, input logic [7:0] code);
        if (ext) return (code == 8'h14) ? {1'b1, KB_SS} : 7'd0;
        case (code)
            8'h12, 8'h59: return {1'b1, KB_CS};
            8'h1A: return {1'b1, KB_Z};   8'h22: return {1'b1, KB_X};   8'h21: return {1'b1, KB_C};
            8'h2A: return {1'b1, KB_V};   8'h1C: return {1'b1, KB_A};   8'h1B: return {1'b1, KB_S};
            8'h23: return {1'b1, KB_D};   8'h2B: return {1'b1, KB_F};   8'h34: return {1'b1, KB_G};
            8'h15: return {1'b1, KB_Q};   8'h1D: return {1'b1, KB_W};   8'h24: return {1'b1, KB_E};
            8'h2D: return {1'b1, KB_R};   8'h2C: return {1'b1, KB_T};   8'h16: return {1'b1, KB_1};
            8'h1E: return {1'b1, KB_2};   8'h26: return {1'b1, KB_3};   8'h25: return {1'b1, KB_4};
            8'h2E: return {1'b1, KB_5};   8'h45: return {1'b1, KB_0};   8'h46: return {1'b1, KB_9};
            8'h3E: return {1'b1, KB_8};   8'h3D: return {1'b1, KB_7};   8'h36: return {1'b1, KB_6};
            8'h4D: return {1'b1, KB_P};   8'h44: return {1'b1, KB_O};   8'h43: return {1'b1, KB_I};
            8'h3C: return {1'b1, KB_U};   8'h35: return {1'b1, KB_Y};   8'h5A: return {1'b1, KB_ENT};
            8'h4B: return {1'b1, KB_L};   8'h42: return {1'b1, KB_K};   8'h3B: return {1'b1, KB_J};
            8'h33: return {1'b1, KB_H};   8'h29: return {1'b1, KB_SP};  8'h14: return {1'b1, KB_SS};
            8'h3A: return {1'b1, KB_M};   8'h31: return {1'b1, KB_N};   8'h32: return {1'b1, KB_B};
            default: return 7'd0;
        endcase
    endfunction
    // {ext, code} -> {hit, composite slot}: 0 Backspace, 1 Left, 2 Down, 3 Up, 4 Right
    function automatic logic [3:0] comp_map(input logic ext, input logic [7:0] code);
        if (!ext) return (code == 8'h66) ? 4'b1_000 : 4'd0;
        case (code)
            8'h6B: return 4'b1_001;
            8'h72: return 4'b1_010;
            8'h75: return 4'b1_011;
            8'h74: return 4'b1_100;
            default: return 4'd0;
        endcase
    endfunction
    // composite slot -> matrix bits it presses (always CS plus one key)
    function automatic logic [39:0] comp_exp(input logic [2:0] slot);
        logic [5:0] key;
        key = (slot == 3'd0) ? KB_0 : (slot == 3'd1) ? KB_5 : (slot == 3'd2) ? KB_6 :
              (slot == 3'd3) ? KB_7 : KB_8;
        return (40'd1 << KB_CS) | (40'd1 << key);
    endfunction
endpackage

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 byte receiver with input synchronisers, clock glitch filter, frame FSM and timeout
// Ports: clk/rst system clock and sync reset; ps2_clk_i/ps2_data_i raw PS/2 lines;
//        byte_valid_o strobe with byte_o for each good frame; err_o strobe on any frame error.
module ps2_rx
    import kb_ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 3250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       err_o
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [1:0]    clk_s_q, dat_s_q;
    logic          filt_q, par_q, fall, d;
    logic [FW-1:0] flt_q;
    logic [TW-1:0] to_q;
    logic [2:0]    bit_q;
    logic [7:0]    sh_q;
    rx_state_e     st_q;
    // the filtered clock flips on the FILTER_LEN-th consecutive differing sample
    assign fall = filt_q && !clk_s_q[1] && flt_q == FW'(FILTER_LEN - 1);
    assign d    = dat_s_q[1];
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_s_q      <= 2'b11;
            dat_s_q      <= 2'b11;
            filt_q       <= 1'b1;
            flt_q        <= '0;
            to_q         <= '0;
            st_q         <= RX_IDLE;
            bit_q        <= 3'd0;
            sh_q         <= 8'd0;
            par_q        <= 1'b0;
            byte_valid_o <= 1'b0;
            byte_o       <= 8'd0;
            err_o        <= 1'b0;
        end else begin
            byte_valid_o <= 1'b0;
            err_o        <= 1'b0;
            clk_s_q      <= {clk_s_q[0], ps2_clk_i};
            dat_s_q      <= {dat_s_q[0], ps2_data_i};
            flt_q        <= (clk_s_q[1] == filt_q || flt_q == FW'(FILTER_LEN - 1)) ? '0 : flt_q + 1'b1;
            if (clk_s_q[1] != filt_q && flt_q == FW'(FILTER_LEN - 1)) filt_q <= clk_s_q[1];
            to_q <= (st_q == RX_IDLE || fall) ? '0 : to_q + 1'b1;
            if (fall) begin
                case (st_q)
                    RX_IDLE: begin
                        err_o <= d;
                        st_q  <= d ? RX_IDLE : RX_DATA;
                        bit_q <= 3'd0;
                    end
                    RX_DATA: begin
                        sh_q  <= {d, sh_q[7:1]};
                        bit_q <= bit_q + 3'd1;
                        if (bit_q == 3'd7) st_q <= RX_PARITY;
                    end
                    RX_PARITY: begin
                        par_q <= d;
                        st_q  <= RX_STOP;
                    end
                    RX_STOP: begin
                        st_q <= RX_IDLE;
                        if (d && ^{sh_q, par_q}) begin
                            byte_valid_o <= 1'b1;
                            byte_o       <= sh_q;
                        end else err_o <= 1'b1;
                    end
                endcase
            end else if (st_q != RX_IDLE && to_q == TW'(TIMEOUT_CYC - 1)) begin
                err_o <= 1'b1;
                st_q  <= RX_IDLE;
            end
        end
    end
endmodule

// File: rtl/ps2_kb_matrix.sv
// ps2_kb_matrix: PS/2 set-2 keyboard decoder maintaining a Spectrum-style 8x5 held-key matrix
// Ports: clk/rst CPU clock and sync reset; ps2_clk/ps2_data raw PS/2 lines;
//        kb_state held keys (bit = row*5+col); scan_valid/scan_code received byte; frame_err error strobe.
// Optional: define KB_COMPOSITE_KEYS_EN to decode Backspace and cursor keys as CS+digit combinations.
module ps2_kb_matrix
    import kb_ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 3250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [39:0] kb_state,
    output logic        scan_valid,
    output logic [7:0]  scan_code,
    output logic        frame_err
);
    logic        rx_valid, rx_err;
    logic [7:0]  rx_byte, code_q;
    logic [39:0] kb_q, kb_d;
    logic        ext_q, ext_d, brk_q, brk_d, sv_q, fe_q;
    logic [2:0]  skip_q, skip_d;
    logic [6:0]  hit_idx;
`ifdef KB_COMPOSITE_KEYS_EN
    logic [4:0]  comp_q, comp_d;
    logic [3:0]  comp_hit;
    logic [39:0] comp_or;
`endif
    ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)) u_rx (
        .clk(clk), .rst(rst), .ps2_clk_i(ps2_clk), .ps2_data_i(ps2_data),
        .byte_valid_o(rx_valid), .byte_o(rx_byte), .err_o(rx_err)
    );
    always_comb begin
        kb_d    = kb_q;
        ext_d   = ext_q;
        brk_d   = brk_q;
        skip_d  = skip_q;
        hit_idx = kb_map(ext_q, rx_byte);
`ifdef KB_COMPOSITE_KEYS_EN
        comp_d   = comp_q;
        comp_hit = comp_map(ext_q, rx_byte);
`endif
        if (rx_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (rx_valid) begin
            if (skip_q != 3'd0) skip_d = skip_q - 3'd1;
            else if (rx_byte == PS2_EXT) ext_d = 1'b1;
            else if (rx_byte == PS2_BRK) brk_d = 1'b1;
            else if (rx_byte != PS2_BAT) begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (rx_byte == PS2_PAUSE) skip_d = 3'(PAUSE_SKIP);
                else if (rx_byte == 8'h00 || rx_byte == 8'hFF) begin
                    kb_d = '0;
`ifdef KB_COMPOSITE_KEYS_EN
                    comp_d = '0;
`endif
                end
                else if (hit_idx[6]) kb_d[hit_idx[5:0]] = !brk_q;
`ifdef KB_COMPOSITE_KEYS_EN
                else if (comp_hit[3]) comp_d[comp_hit[2:0]] = !brk_q;
`endif
            end
        end
    end
`ifdef KB_COMPOSITE_KEYS_EN
    // composite keys OR onto the direct matrix so they never release a physically held key
    always_comb begin
        comp_or = '0;
        for (int i = 0; i < 5; i++) if (comp_q[i]) comp_or |= comp_exp(3'(i));
    end
    assign kb_state = kb_q | comp_or;
`else
    assign kb_state = kb_q;
`endif
    assign scan_valid = sv_q;
    assign scan_code  = code_q;
    assign frame_err  = fe_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            kb_q   <= '0;
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
            skip_q <= 3'd0;
            sv_q   <= 1'b0;
            fe_q   <= 1'b0;
            code_q <= 8'd0;
`ifdef KB_COMPOSITE_KEYS_EN
            comp_q <= '0;
`endif
        end else begin
            kb_q   <= kb_d;
            ext_q  <= ext_d;
            brk_q  <= brk_d;
            skip_q <= skip_d;
            sv_q   <= rx_valid;
            fe_q   <= rx_err;
            if (rx_valid) code_q <= rx_byte;
`ifdef KB_COMPOSITE_KEYS_EN
            comp_q <= comp_d;
`endif
        end
    end
endmodule

// File: tb/tb_ps2_kb_matrix.sv
// tb_ps2_kb_matrix: scoreboard bench driving PS/2 frames and checking each strobe against queued expectations
module tb_ps2_kb_matrix;
    localparam int HB  = 20;
    localparam int TMO = 3250;
    localparam logic [39:0] K = 40'h08_0000_8003;
`ifdef KB_COMPOSITE_KEYS_EN
    localparam logic [39:0] KC = 40'h08_0010_8003;
`else
    localparam logic [39:0] KC = K;
`endif
    localparam logic [7:0] PAUSE_TAIL [7] = '{8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    typedef struct {
        logic        err;
        logic [7:0]  code;
        logic [39:0] kb;
    } exp_t;
    logic        clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
    logic [39:0] kb_state;
    logic        scan_valid, frame_err;
    logic [7:0]  scan_code;
    exp_t        sb[$];
    exp_t        got_e;
    int          n_chk = 0, n_pass = 0;
    always #5 clk = ~clk;
    ps2_kb_matrix dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .kb_state(kb_state), .scan_valid(scan_valid), .scan_code(scan_code), .frame_err(frame_err)
    );
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    task automatic push_exp(input logic err, input logic [7:0] code, input logic [39:0] kb);
        exp_t e;
        e.err  = err;
        e.code = code;
        e.kb   = kb;
        sb.push_back(e);
    endtask
    task automatic ps2_bit(input logic b);
        @(negedge clk) ps2_data = b;
        repeat (HB) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HB) @(negedge clk);
        ps2_clk = 1'b1;
    endtask
    task automatic send(input logic [7:0] b, input logic [39:0] kb, input logic bad = 1'b0);
        push_exp(bad, b, kb);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(~^b ^ bad);
        ps2_bit(1'b1);
        repeat (40) @(negedge clk);
    endtask
    task automatic partial(input int n);
        ps2_bit(1'b0);
        for (int i = 0; i < n; i++) ps2_bit(1'b1);
    endtask
    always @(negedge clk) begin
        if (!rst && (scan_valid || frame_err)) begin
            if (sb.size() == 0) chk("unexpected_strobe", {62'd0, scan_valid, frame_err}, 64'd0);
            else begin
                got_e = sb.pop_front();
                chk("frame_err", frame_err, got_e.err);
                chk("scan_valid", scan_valid, !got_e.err);
                if (!got_e.err) chk("scan_code", scan_code, got_e.code);
                chk("kb_state", kb_state, got_e.kb);
            end
        end
    end
    initial begin
        repeat (4) @(negedge clk);
        rst = 1'b0;
        chk("rst_kb", kb_state, 0);
        chk("rst_sv", scan_valid, 0);
        chk("rst_code", scan_code, 0);
        chk("rst_fe", frame_err, 0);
        send(8'h1C, 40'h20);
        send(8'hF0, 40'h20);
        send(8'h1C, 40'h0);
        send(8'h12, 40'h1);
        send(8'h5A, 40'h00_4000_0001);
        send(8'h29, 40'h08_4000_0001);
        send(8'hF0, 40'h08_4000_0001);
        send(8'h5A, 40'h08_0000_0001);
        send(8'h1A, 40'h08_0000_0001, 1'b1);
        send(8'h1A, 40'h08_0000_0003);
        push_exp(1'b1, 8'h00, 40'h08_0000_0003);
        partial(4);
        repeat (TMO + 300) @(negedge clk);
        send(8'h16, K);
        send(8'h66, KC);
        send(8'hF0, KC);
        send(8'h66, K);
        send(8'hE0, K);
        send(8'h14, 40'h18_0000_8003);
        send(8'hE0, 40'h18_0000_8003);
        send(8'hF0, 40'h18_0000_8003);
        send(8'h14, K);
        send(8'h1A, K);
        send(8'hE1, K);
        for (int i = 0; i < 7; i++) send(PAUSE_TAIL[i], K);
        send(8'h1C, 40'h08_0000_8023);
        send(8'h00, 40'h0);
        send(8'h1C, 40'h20);
        partial(3);
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        chk("midrst_kb", kb_state, 0);
        chk("midrst_sv", scan_valid, 0);
        chk("midrst_code", scan_code, 0);
        chk("midrst_fe", frame_err, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        send(8'h1C, 40'h20);
        repeat (100) @(negedge clk);
        chk("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ps2_kb_matrix.md
Name: ps2_kb_matrix

Overview:
- Upstream source of the 40-bit `kb_state` vector consumed by the computer top / `kb_n_tape`.
- Receives a PS/2 keyboard stream (scan code set 2), decodes make/break sequences and maintains a held-key matrix in a Spectrum-style 8×5 layout.
- Runs in the CPU clock domain; replaces the raw switch matrix when a PS/2 keyboard is fitted.

Parameters:
- `FILTER_LEN`, 8: consecutive identical samples required before the filtered `ps2_clk` level changes.
- `TIMEOUT_CYC`, 3250: idle `clk` cycles mid-frame before the partial frame is aborted (about 1 ms at 3.25 MHz).

Ports:
- `clk`  in  1  — system clock, the CPU clock.
- `rst`  in  1  — synchronous, active-high reset.
- `ps2_clk`  in  1  — raw PS/2 clock; asynchronous, open-collector, idle high.
- `ps2_data`  in  1  — raw PS/2 data; asynchronous.
- `kb_state`  out  40  — held-key matrix; bit = row*5+col; 1 = pressed.
- `scan_valid`  out  1  — one-cycle strobe for each correctly received byte.
- `scan_code`  out  8  — last received byte; valid while `scan_valid` is high, held otherwise.
- `frame_err`  out  1  — one-cycle strobe on parity, start-bit, stop-bit or timeout error.

Behaviour:
- **Reset:** `kb_state`=0, `scan_valid`=0, `scan_code`=0x00, `frame_err`=0, all prefix flags clear, receiver in IDLE.
- **Input conditioning:**
  - 2-flop synchronisers on both PS/2 inputs.
  - `ps2_clk` passes through a `FILTER_LEN` glitch filter.
  - A bit is sampled from synchronised `ps2_data` on the filtered falling edge.
- **Receiver FSM:** IDLE → DATA (8 bits, LSB first) → PARITY → STOP → IDLE.
  - Start bit must be 0, otherwise `frame_err`, back to IDLE.
  - Parity must make the 9 bits odd-weight.
  - Stop bit must be 1.
  - Any error: `frame_err` pulse, byte discarded, decoder prefix flags cleared, `kb_state` unchanged.
- **Timeout:** outside IDLE, a counter counts cycles without a falling edge. Reaching `TIMEOUT_CYC` gives a `frame_err` pulse and a return to IDLE. The counter restarts on every edge.
- **Latency:** stop-bit edge detected in cycle N → `scan_valid`, `scan_code` and the updated `kb_state` all visible in cycle N+1.
- **Decoder, prefix bytes:**
  - 0xE0 sets `ext`.
  - 0xF0 sets `brk`.
  - Both flags clear after the next non-prefix byte.
- **Decoder, key bytes:**
  - Mapped code: make sets the bit, break clears it.
  - Unmapped code: ignored, flags cleared.
- **Decoder, special codes:**
  - 0xE1 starts a pause skip: the next 7 bytes are ignored (still strobed on `scan_valid`).
  - 0xAA (BAT) is ignored.
  - 0x00 and 0xFF (overrun) clear all of `kb_state`.
- **Key map:**

  | Row | col0 | col1 | col2 | col3 | col4 |
  |---|---|---|---|---|---|
  | 0 | CS | Z | X | C | V |
  | 1 | A | S | D | F | G |
  | 2 | Q | W | E | R | T |
  | 3 | 1 | 2 | 3 | 4 | 5 |
  | 4 | 0 | 9 | 8 | 7 | 6 |
  | 5 | P | O | I | U | Y |
  | 6 | ENTER | L | K | J | H |
  | 7 | SPACE | SS | M | N | B |

  - CS = L/R Shift (0x12, 0x59).
  - SS = L/R Ctrl (0x14, E0 14).
  - Extended codes map only where listed; others are ignored.
- **Same-key repeats:** typematic make of a held key changes nothing.
- **Simultaneous events:** make/break of different keys never disturb each other.
- **Reset mid-frame:** the partial byte is dropped.

Optional Feature:
- Macro: `KB_COMPOSITE_KEYS_EN`.
- **When defined, composite keys are decoded:**

  | PS/2 key | Code | `kb_state` bits |
  |---|---|---|
  | Backspace | 0x66 | CS + 0 |
  | Left | E0 6B | CS + 5 |
  | Down | E0 72 | CS + 6 |
  | Up | E0 75 | CS + 7 |
  | Right | E0 74 | CS + 8 |

- Composite keys keep a private held-flag vector. `kb_state` = direct matrix OR the expansions of held composite flags, so releasing Backspace does not release a physically held Shift.
- **When undefined:** these codes are unmapped, and `kb_state` is driven by the direct matrix register only.

Decomposition:
- **Package `kb_ps2_pkg`:**
  - Key-index localparams (`KB_CS`=0 … `KB_B`=39).
  - Prefix/special byte constants (0xE0, 0xF0, 0xE1, 0xAA).
  - Mapping function: {ext, code} → {hit, index[5:0]}.
  - Composite table.
- **Sub-module `ps2_rx`:** synchronisers, glitch filter, frame FSM and timeout. It outputs `byte_valid`, `byte`, `err`.
- Decoder and matrix stay in the top level.

Test Plan:
- Frame 0x1C (A, correct parity) → `scan_valid` with `scan_code`=0x1C; `kb_state`=40'h20 (bit 5). Then F0 1C → `kb_state`=0.
- Make 0x12, then 0x5A, then 0x29 → bits 0, 30 and 35 set (`kb_state`=40'h08_4000_0001). Break 0x5A only → bits 0 and 35 remain.
- Frame 0x1A with parity bit flipped → `frame_err` pulse, no `scan_valid`, `kb_state` unchanged. A following valid 0x1A → bit 1 set.
- Start bit, 4 data bits, then bus idle for `TIMEOUT_CYC` → exactly one `frame_err`. A subsequent frame 0x16 → bit 15 set.
- With `KB_COMPOSITE_KEYS_EN`: make 0x12, make 0x66 → bits 0 and 20. Break 0x66 → bit 0 remains, bit 20 clear. Without the macro, 0x66 leaves `kb_state` unchanged.
- Keys held, then byte 0x00 → `kb_state`=0. Assert `rst` mid-frame → all outputs zero next cycle, and the next full frame decodes correctly.
